// File: rtl/mem_bist_pkg.sv
// Shared widths and FSM state type for the 32x8 memory BIST.
package mem_bist_pkg;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 32;

  typedef enum logic [2:0] {
    IDLE,
    WR0,
    RD0,
    WR1,
    RD1,
    DONE
  } state_e;
endpackage

// File: rtl/mem_intf.sv
// Signal bundle between the BIST initiator and the synchronous memory.
interface mem_intf;
  logic                                 read;
  logic                                 write;
  logic [mem_bist_pkg::ADDR_W-1:0]      addr;
  logic [mem_bist_pkg::DATA_W-1:0]      wdata;
  logic [mem_bist_pkg::DATA_W-1:0]      rdata;

  modport initiator (output read, write, addr, wdata, input rdata);
  modport target    (input read, write, addr, wdata, output rdata);
endinterface

// File: rtl/mem_bist.sv
// Two-pass write/read-back BIST (PATTERN then ~PATTERN) for a 32x8 synchronous memory.
module mem_bist
  import mem_bist_pkg::*;
#(
  parameter logic [DATA_W-1:0] PATTERN = 8'h55
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] data_in
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e              state_q;
  logic                busy_q, done_q, pass_q;
  logic                read_q, write_q;
  logic [ADDR_W-1:0]   addr_q, fail_addr_q, caddr_q;
  logic [DATA_W-1:0]   wdata_q, fail_data_q, exp_q;
  logic                cv_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      cv_q        <= 1'b0;
      caddr_q     <= '0;
      exp_q       <= '0;
    end else begin
      // Compare pipeline: a read issued this cycle is checked one cycle after the memory registers it.
      cv_q    <= read_q;
      caddr_q <= addr_q;
      exp_q   <= (state_q == RD1) ? ~PATTERN : PATTERN;

      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q     <= WR0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            write_q     <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= PATTERN;
          end
        end
        WR0, WR1: begin
          if (addr_q == LAST) begin
            state_q <= (state_q == WR0) ? RD0 : RD1;
            write_q <= 1'b0;
            wdata_q <= '0;
            read_q  <= 1'b1;
            addr_q  <= '0;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        RD0, RD1: begin
          if (cv_q && (data_in != exp_q)) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            pass_q      <= 1'b0;
            read_q      <= 1'b0;
            addr_q      <= '0;
            fail_addr_q <= caddr_q;
            fail_data_q <= data_in;
            cv_q        <= 1'b0;
          end else if (!read_q) begin
            // Drain cycle: the last read has just been compared.
            addr_q <= '0;
            if (state_q == RD0) begin
              state_q <= WR1;
              write_q <= 1'b1;
              wdata_q <= ~PATTERN;
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end
          end else if (addr_q == LAST) begin
            read_q <= 1'b0;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign read      = read_q;
  assign write     = write_q;
  assign addr      = addr_q;
  assign data_out  = wdata_q;

endmodule

// File: tb/tb_mem_bist.sv
// Scoreboard bench: two BIST instances (PATTERN 55 and 00) each driving a fault-injectable memory.
module tb_mem_bist;
  import mem_bist_pkg::*;

  typedef struct {
    logic        pass;
    logic [4:0]  fa;
    logic [7:0]  fd;
    int unsigned cyc;
    int unsigned nwr;
    int unsigned nwr1;
  } exp_t;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic sel = 1'b0;

  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [4:0] fa_a, fa_b;
  logic [7:0] fd_a, fd_b;

  logic [4:0] flt_addr_a = '0, flt_addr_b = '0;
  logic [7:0] s0_a = '0, s1_a = '0, s0_b = '0, s1_b = '0;
  logic [7:0] mem_a [DEPTH];
  logic [7:0] mem_b [DEPTH];

  int unsigned checks = 0, errors = 0;
  exp_t sb[$];

  mem_intf ma ();
  mem_intf mb ();

  always #5 clk = ~clk;

  mem_bist #(.PATTERN(8'h55)) u_dut_a (
    .clk(clk), .rst_(rst_), .start(start_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_addr(fa_a), .fail_data(fd_a), .read(ma.read), .write(ma.write), .addr(ma.addr),
    .data_out(ma.wdata), .data_in(ma.rdata)
  );

  mem_bist #(.PATTERN(8'h00)) u_dut_b (
    .clk(clk), .rst_(rst_), .start(start_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_addr(fa_b), .fail_data(fd_b), .read(mb.read), .write(mb.write), .addr(mb.addr),
    .data_out(mb.wdata), .data_in(mb.rdata)
  );

  function automatic logic [7:0] rd_fault(input logic [7:0] d, input logic [4:0] a,
                                          input logic [4:0] fa, input logic [7:0] s0,
                                          input logic [7:0] s1);
    return (a == fa) ? ((d & ~s0) | s1) : d;
  endfunction

  initial begin
    ma.rdata = '0;
    mb.rdata = '0;
  end

  always @(posedge clk) begin
    if (ma.write) mem_a[ma.addr] <= ma.wdata;
    if (ma.read)  ma.rdata <= rd_fault(mem_a[ma.addr], ma.addr, flt_addr_a, s0_a, s1_a);
    if (mb.write) mem_b[mb.addr] <= mb.wdata;
    if (mb.read)  mb.rdata <= rd_fault(mem_b[mb.addr], mb.addr, flt_addr_b, s0_b, s1_b);
  end

  logic       obs_busy, obs_done, obs_pass, obs_read, obs_write;
  logic [4:0] obs_addr, obs_fa;
  logic [7:0] obs_wdata, obs_fd, obs_patt;

  always_comb begin
    obs_busy  = sel ? busy_b   : busy_a;
    obs_done  = sel ? done_b   : done_a;
    obs_pass  = sel ? pass_b   : pass_a;
    obs_read  = sel ? mb.read  : ma.read;
    obs_write = sel ? mb.write : ma.write;
    obs_addr  = sel ? mb.addr  : ma.addr;
    obs_wdata = sel ? mb.wdata : ma.wdata;
    obs_fa    = sel ? fa_b     : fa_a;
    obs_fd    = sel ? fd_b     : fd_a;
    obs_patt  = sel ? 8'h00    : 8'h55;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic p, input logic [4:0] fa, input logic [7:0] fd,
                          input int unsigned cyc, input int unsigned nwr, input int unsigned nwr1);
    exp_t e;
    e.pass = p; e.fa = fa; e.fd = fd; e.cyc = cyc; e.nwr = nwr; e.nwr1 = nwr1;
    sb.push_back(e);
  endtask

  // Monitor: per-cycle protocol checks plus scoreboard pop on each rising done.
  logic        busy_p = 1'b0, done_p = 1'b0, wr_p = 1'b0, rd_p = 1'b0;
  logic [4:0]  addr_p = '0;
  int unsigned cyc = 0, nwr = 0, nwr1 = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_) begin
      check("rd_wr_exclusive", {31'd0, obs_read & obs_write}, 32'd0);
      if (obs_write && wr_p) check("wr_addr_inc", {27'd0, obs_addr}, {27'd0, 5'(addr_p + 5'd1)});
      if (obs_read && rd_p)  check("rd_addr_inc", {27'd0, obs_addr}, {27'd0, 5'(addr_p + 5'd1)});
      if (obs_busy && !busy_p) begin
        cyc  = 1;
        nwr  = obs_write ? 1 : 0;
        nwr1 = (obs_write && obs_wdata == ~obs_patt) ? 1 : 0;
      end else if (obs_busy) begin
        cyc++;
        if (obs_write) nwr++;
        if (obs_write && obs_wdata == ~obs_patt) nwr1++;
      end
      if (obs_done && !done_p) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 expected=0");
        end else begin
          e = sb.pop_front();
          check("pass",        {31'd0, obs_pass}, {31'd0, e.pass});
          check("fail_addr",   {27'd0, obs_fa},   {27'd0, e.fa});
          check("fail_data",   {24'd0, obs_fd},   {24'd0, e.fd});
          check("busy_cycles", cyc,  e.cyc);
          check("write_count", nwr,  e.nwr);
          check("inv_writes",  nwr1, e.nwr1);
        end
      end
    end
    busy_p = obs_busy;
    done_p = obs_done;
    wr_p   = obs_write;
    rd_p   = obs_read;
    addr_p = obs_addr;
  end

  task automatic pulse_a();
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
  endtask

  task automatic pulse_b();
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int unsigned n = 0;
    while (!obs_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!obs_done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=0 expected=1", name);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_a"}, {1'b0, busy_a, done_a, pass_a, ma.read, ma.write, ma.addr, ma.wdata, fa_a, fd_a}, 32'd0);
    check({name, "_b"}, {1'b0, busy_b, done_b, pass_b, mb.read, mb.write, mb.addr, mb.wdata, fa_b, fd_b}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_state");
    rst_ = 1'b1;
    @(negedge clk);

    // Good memory, PATTERN 55.
    push_exp(1'b1, 5'd0, 8'h00, 130, 64, 32);
    pulse_a();
    wait_done("good_run");

    // Bit 0 stuck-at-0 at addr 5: caught in RD0, no WR1 writes.
    flt_addr_a = 5'd5; s0_a = 8'h01;
    push_exp(1'b0, 5'd5, 8'h54, 39, 32, 0);
    pulse_a();
    wait_done("stuck0_run");

    // Restart from DONE clears result registers.
    s0_a = 8'h00;
    push_exp(1'b1, 5'd0, 8'h00, 130, 64, 32);
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    check("restart_clear", {17'd0, done_a, pass_a, fa_a, fd_a, busy_a}, 32'd1);
    wait_done("restart_run");

    // start during busy is ignored.
    push_exp(1'b1, 5'd0, 8'h00, 130, 64, 32);
    pulse_a();
    repeat (9) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    wait_done("ignore_start_run");

    // PATTERN 00, bit 7 stuck-at-1 at addr 31: caught in RD0 drain cycle.
    @(negedge clk);
    #1 sel = 1'b1;
    flt_addr_b = 5'd31; s1_b = 8'h80;
    push_exp(1'b0, 5'd31, 8'h80, 65, 32, 0);
    pulse_b();
    wait_done("stuck1_run");
    @(negedge clk);
    #1 sel = 1'b0;

    // Asynchronous reset during WR1 aborts; a later run completes.
    pulse_a();
    repeat (70) @(negedge clk);
    check("in_wr1_write", {31'd0, ma.write}, 32'd1);
    #2 rst_ = 1'b0;
    #1 check_idle_outputs("async_reset");
    @(negedge clk);
    #1 rst_ = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("post_reset_idle");
    push_exp(1'b1, 5'd0, 8'h00, 130, 64, 32);
    pulse_a();
    wait_done("after_reset_run");

    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_pending actual=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
